// File: rtl/occupancy_pkg.sv
// Shared types and constants for the occupancy-grid update controller.
package occupancy_pkg;

    localparam int X_WIDTH = 5;
    localparam int Y_WIDTH = 4;
    localparam int DATA_W  = 8;

    localparam logic [DATA_W-1:0] SAT_MIN_DEFAULT = 8'd0;
    localparam logic [DATA_W-1:0] SAT_MAX_DEFAULT = 8'd255;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLR_INIT  = 3'd1,
        CLR_RUN   = 3'd2,
        UPD_READ  = 3'd3,
        UPD_WRITE = 3'd4,
        DONE      = 3'd5
    } occ_state_t;

endpackage

// File: rtl/occupancy_sat_check.sv
// Decides whether a log-odds update would push a cell past its saturation limit.
module occupancy_sat_check
    import occupancy_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    input  logic              free_i,
    input  logic [DATA_W-1:0] sat_min_i,
    input  logic [DATA_W-1:0] sat_max_i,
    output logic              suppress_o
);

    assign suppress_o = free_i ? (data_i == sat_min_i) : (data_i == sat_max_i);

endmodule

// File: rtl/occupancy_control.sv
// Command FSM for the occupancy map: full-map clear sweeps and single-cell
// read-modify-write log-odds updates against an external RAM datapath.
module occupancy_control
    import occupancy_pkg::*;
#(
    parameter int                RAM_LATENCY = 1,
    parameter logic [DATA_W-1:0] SAT_MIN     = SAT_MIN_DEFAULT,
    parameter logic [DATA_W-1:0] SAT_MAX     = SAT_MAX_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_clear,
    input  logic               cmd_free,
    input  logic [X_WIDTH-1:0] cmd_x,
    input  logic [Y_WIDTH-1:0] cmd_y,
    output logic               done,
    output logic               saturated,
    input  logic [DATA_W-1:0]  data_out,
    input  logic               count_done,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               zero_cell,
    output logic               write_enable,
    output logic               cell_is_free,
    output logic               reset_counter,
    output logic               enable_counter
);

    // Down-counter preload: UPD_READ exits when the counter reaches zero.
    localparam logic [1:0] LAT_INIT = 2'(RAM_LATENCY - 1);

    occ_state_t         state_q, state_d;
    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;
    logic               free_q, free_d;
    logic               sat_q, sat_d;
    logic [1:0]         lat_q, lat_d;
    logic               suppress;

    occupancy_sat_check u_sat_check (
        .data_i     (data_out),
        .free_i     (free_q),
        .sat_min_i  (SAT_MIN),
        .sat_max_i  (SAT_MAX),
        .suppress_o (suppress)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            free_q  <= 1'b0;
            sat_q   <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            free_q  <= free_d;
            sat_q   <= sat_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        free_d  = free_q;
        sat_d   = sat_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    sat_d = 1'b0;
                    if (cmd_clear) begin
                        state_d = CLR_INIT;
                    end else begin
                        state_d = UPD_READ;
                        x_d     = cmd_x;
                        y_d     = cmd_y;
                        free_d  = cmd_free;
                        lat_d   = LAT_INIT;
                    end
                end
            end
            CLR_INIT: state_d = CLR_RUN;
            CLR_RUN: begin
                if (count_done) state_d = DONE;
            end
            UPD_READ: begin
                if (lat_q == 2'd0) state_d = UPD_WRITE;
                else               lat_d   = lat_q - 2'd1;
            end
            UPD_WRITE: begin
                sat_d   = suppress;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes decode from the registered state only, so an async reset clears them at once.
    always_comb begin
        cmd_ready      = 1'b0;
        done           = 1'b0;
        saturated      = 1'b0;
        zero_cell      = 1'b0;
        write_enable   = 1'b0;
        cell_is_free   = 1'b0;
        reset_counter  = 1'b0;
        enable_counter = 1'b0;
        case (state_q)
            IDLE:     cmd_ready = 1'b1;
            CLR_INIT: begin
                reset_counter = 1'b1;
                zero_cell     = 1'b1;
            end
            CLR_RUN: begin
                zero_cell      = 1'b1;
                write_enable   = 1'b1;
                enable_counter = 1'b1;
            end
            UPD_WRITE: begin
                cell_is_free = free_q;
                write_enable = ~suppress;
            end
            DONE: begin
                done      = 1'b1;
                saturated = sat_q;
            end
            default: ;
        endcase
    end

    assign x = x_q;
    assign y = y_q;

endmodule

// File: tb/tb_occupancy_control.sv
// Directed bench with a RAM/sweep-counter model and a queue of expected completions.
module tb_occupancy_control;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0, cmd_clear = 1'b0, cmd_free = 1'b0;
    logic [4:0] cmd_x = '0;
    logic [3:0] cmd_y = '0;
    logic       cmd_ready, done, saturated;
    logic [7:0] data_out;
    logic       count_done;
    logic [4:0] x;
    logic [3:0] y;
    logic       zero_cell, write_enable, cell_is_free, reset_counter, enable_counter;

    occupancy_control dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_clear(cmd_clear), .cmd_free(cmd_free),
        .cmd_x(cmd_x), .cmd_y(cmd_y),
        .done(done), .saturated(saturated),
        .data_out(data_out), .count_done(count_done),
        .x(x), .y(y),
        .zero_cell(zero_cell), .write_enable(write_enable), .cell_is_free(cell_is_free),
        .reset_counter(reset_counter), .enable_counter(enable_counter)
    );

    always #5 clock = ~clock;

    // Datapath model: 512-cell RAM with one-cycle read latency and a sweep counter.
    logic [7:0] mem [512];
    logic [8:0] sweep = '0;
    logic [7:0] rd_q = '0;
    logic       pl_en = 1'b0;
    logic [8:0] pl_addr = '0;
    logic [7:0] pl_val = '0;

    always @(posedge clock) begin
        if (pl_en)
            mem[pl_addr] <= pl_val;
        else if (write_enable) begin
            if (zero_cell) mem[sweep] <= 8'd0;
            else if (cell_is_free) mem[{y, x}] <= mem[{y, x}] - 8'd1;
            else mem[{y, x}] <= mem[{y, x}] + 8'd1;
        end
        rd_q <= mem[{y, x}];
        if (reset_counter) sweep <= '0;
        else if (enable_counter) sweep <= sweep + 9'd1;
    end

    assign data_out   = rd_q;
    assign count_done = (sweep == 9'd511);

    typedef struct {
        string tag;
        int    lat;
        bit    sat;
        int    wr;
        int    zw;
        int    rc;
    } exp_t;

    exp_t exp_q[$];
    int   acc_log[$];
    int   done_log[$];
    int   checks = 0, errors = 0;
    int   cyc = 0, acc_cyc = 0, wr_cnt = 0, zw_cnt = 0, rc_cnt = 0;
    int   idle_wr = 0, strobe_viol = 0;
    bit   active = 1'b0;
    exp_t mon_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, expv);
        end
    endtask

    always @(negedge clock) begin
        cyc++;
        if (write_enable && cmd_ready) idle_wr++;
        if (reset_counter && (!zero_cell || write_enable)) strobe_viol++;
        if (write_enable && zero_cell && !enable_counter) strobe_viol++;
        if (done && (write_enable || zero_cell || reset_counter || enable_counter)) strobe_viol++;
        if (saturated && !done) strobe_viol++;
        if (reset) begin
            active = 1'b0;
        end else begin
            if (done) begin
                done_log.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.tag, "_latency"}, cyc - acc_cyc, mon_e.lat);
                    check({mon_e.tag, "_saturated"}, {31'd0, saturated}, {31'd0, mon_e.sat});
                    check({mon_e.tag, "_writes"}, wr_cnt, mon_e.wr);
                    check({mon_e.tag, "_zero_writes"}, zw_cnt, mon_e.zw);
                    check({mon_e.tag, "_reset_counter"}, rc_cnt, mon_e.rc);
                    active = 1'b0;
                end
            end
            if (active) begin
                if (write_enable) wr_cnt++;
                if (write_enable && zero_cell) zw_cnt++;
                if (reset_counter) rc_cnt++;
            end
            if (cmd_valid && cmd_ready) begin
                active  = 1'b1;
                acc_cyc = cyc;
                wr_cnt  = 0;
                zw_cnt  = 0;
                rc_cnt  = 0;
                acc_log.push_back(cyc);
            end
        end
    end

    task automatic push(input string tag, input int lat, input bit sat, input int wr, input int zw, input int rc);
        exp_t e;
        e.tag = tag; e.lat = lat; e.sat = sat; e.wr = wr; e.zw = zw; e.rc = rc;
        exp_q.push_back(e);
    endtask

    task automatic poke(input logic [8:0] a, input logic [7:0] v);
        pl_en = 1'b1; pl_addr = a; pl_val = v;
        @(posedge clock); #1;
        pl_en = 1'b0;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        @(negedge clock);
        while (!cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_accept"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clock); #1;
    endtask

    task automatic issue(input string tag, input logic clr, input logic fr, input logic [4:0] cx, input logic [3:0] cy);
        cmd_clear = clr; cmd_free = fr; cmd_x = cx; cmd_y = cy; cmd_valid = 1'b1;
        wait_accept(tag);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_done_seen"}, exp_q.size(), 32'd0);
        @(posedge clock); #1;
    endtask

    function automatic int nonzero_cells();
        int c = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== 8'd0) c++;
        return c;
    endfunction

    initial begin
        #2 reset = 1'b1;
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_done_sat", {30'd0, done, saturated}, 32'd0);
        check("rst_strobes", {27'd0, zero_cell, write_enable, cell_is_free, reset_counter, enable_counter}, 32'd0);
        check("rst_x", {27'd0, x}, 32'd0);
        check("rst_y", {28'd0, y}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // Full-map clear: 512 sweep cycles, done at accept+514.
        push("clear", 514, 1'b0, 512, 512, 1);
        issue("clear", 1'b1, 1'b0, 5'd0, 4'd0);
        wait_idle("clear");
        check("clear_all_zero", nonzero_cells(), 32'd0);

        poke({4'd7, 5'd3}, 8'd10);
        push("upd_occ", 3, 1'b0, 1, 0, 0);
        issue("upd_occ", 1'b0, 1'b0, 5'd3, 4'd7);
        wait_idle("upd_occ");
        check("upd_occ_mem", {24'd0, mem[{4'd7, 5'd3}]}, 32'd11);

        poke({4'd2, 5'd1}, 8'd0);
        push("sat_min", 3, 1'b1, 0, 0, 0);
        issue("sat_min", 1'b0, 1'b1, 5'd1, 4'd2);
        wait_idle("sat_min");
        check("sat_min_mem", {24'd0, mem[{4'd2, 5'd1}]}, 32'd0);

        poke({4'd15, 5'd31}, 8'd255);
        push("sat_max", 3, 1'b1, 0, 0, 0);
        issue("sat_max", 1'b0, 1'b0, 5'd31, 4'd15);
        wait_idle("sat_max");
        check("sat_max_mem", {24'd0, mem[{4'd15, 5'd31}]}, 32'd255);

        poke({4'd15, 5'd31}, 8'd254);
        push("below_max", 3, 1'b0, 1, 0, 0);
        issue("below_max", 1'b0, 1'b0, 5'd31, 4'd15);
        wait_idle("below_max");
        check("below_max_mem", {24'd0, mem[{4'd15, 5'd31}]}, 32'd255);

        push("free_at_max", 3, 1'b0, 1, 0, 0);
        issue("free_at_max", 1'b0, 1'b1, 5'd31, 4'd15);
        wait_idle("free_at_max");
        check("free_at_max_mem", {24'd0, mem[{4'd15, 5'd31}]}, 32'd254);

        push("occ_at_min", 3, 1'b0, 1, 0, 0);
        issue("occ_at_min", 1'b0, 1'b0, 5'd1, 4'd2);
        wait_idle("occ_at_min");
        check("occ_at_min_mem", {24'd0, mem[{4'd2, 5'd1}]}, 32'd1);

        // Reset on the 100th CLR_RUN cycle: cells 0..98 cleared, cell 99 untouched.
        poke(9'd0, 8'd5);
        poke(9'd98, 8'd7);
        poke(9'd99, 8'd9);
        push("aborted_clear", 514, 1'b0, 512, 512, 1);
        issue("aborted_clear", 1'b1, 1'b0, 5'd0, 4'd0);
        repeat (100) @(posedge clock);
        #1;
        check("abort_in_clr_run", {31'd0, write_enable}, 32'd1);
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("abort_strobes", {26'd0, zero_cell, write_enable, cell_is_free, reset_counter, enable_counter, done}, 32'd0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("abort_cell0", {24'd0, mem[0]}, 32'd0);
        check("abort_cell98", {24'd0, mem[98]}, 32'd0);
        check("abort_cell99", {24'd0, mem[99]}, 32'd9);

        poke(9'd4, 8'd40);
        push("post_abort", 3, 1'b0, 1, 0, 0);
        issue("post_abort", 1'b0, 1'b1, 5'd4, 4'd0);
        wait_idle("post_abort");
        check("post_abort_mem", {24'd0, mem[4]}, 32'd39);

        // Back-to-back updates with cmd_valid held high throughout.
        poke({4'd1, 5'd5}, 8'd20);
        poke({4'd1, 5'd6}, 8'd30);
        acc_log.delete();
        done_log.delete();
        push("b2b_first", 3, 1'b0, 1, 0, 0);
        push("b2b_second", 3, 1'b0, 1, 0, 0);
        cmd_clear = 1'b0; cmd_free = 1'b0; cmd_x = 5'd5; cmd_y = 4'd1; cmd_valid = 1'b1;
        wait_accept("b2b_first");
        cmd_x = 5'd6;
        wait_accept("b2b_second");
        cmd_valid = 1'b0;
        wait_idle("b2b");
        check("b2b_accepts", acc_log.size(), 32'd2);
        check("b2b_second_after_done", acc_log[1], done_log[0] + 1);
        check("b2b_mem_first", {24'd0, mem[{4'd1, 5'd5}]}, 32'd21);
        check("b2b_mem_second", {24'd0, mem[{4'd1, 5'd6}]}, 32'd31);

        // Clear dominates free.
        poke(9'd300, 8'd77);
        push("clear_free", 514, 1'b0, 512, 512, 1);
        issue("clear_free", 1'b1, 1'b1, 5'd9, 4'd9);
        wait_idle("clear_free");
        check("clear_free_all_zero", nonzero_cells(), 32'd0);

        repeat (3) @(posedge clock);
        #1;
        check("idle_writes", idle_wr, 32'd0);
        check("strobe_rules", strobe_viol, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/occupancy_control.md
OCCUPANCY_CONTROL -- requirements
Module: occupancy_control

Interface
REQ-001 Parameter RAM_LATENCY, default 1: cycles from cell address valid to data_out valid; legal range 1..3.
REQ-002 Parameter SAT_MIN, default 8'd0: lowest log-odds value; a free update on a cell at SAT_MIN is suppressed.
REQ-003 Parameter SAT_MAX, default 8'd255: highest log-odds value; an occupied update on a cell at SAT_MAX is suppressed.
REQ-004 Port clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port cmd_valid, input, 1 bit: command present.
REQ-007 Port cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-008 Port cmd_clear, input, 1 bit: command is a full-map clear; it dominates cmd_free.
REQ-009 Port cmd_free, input, 1 bit: for an update, 1 means the cell is observed free (decrement) and 0 means occupied (increment).
REQ-010 Port cmd_x, input, 5 bits and cmd_y, input, 4 bits: target cell of an update; ignored for a clear.
REQ-011 Port done, output, 1 bit: one-cycle pulse when a command completes.
REQ-012 Port saturated, output, 1 bit: one-cycle pulse with done when an update write was suppressed.
REQ-013 Port data_out, input, 8 bits: current cell value from the datapath.
REQ-014 Port count_done, input, 1 bit: datapath sweep counter at last cell.
REQ-015 Ports x (5 bits), y (4 bits), zero_cell, write_enable, cell_is_free, reset_counter and enable_counter: outputs that drive the datapath.

Function
REQ-016 The FSM SHALL have states IDLE, CLR_INIT, CLR_RUN, UPD_READ, UPD_WRITE and DONE.
REQ-017 cmd_ready SHALL be 1 only in IDLE, so one command is in flight at a time.
REQ-018 From IDLE, an accepted command SHALL go to CLR_INIT if cmd_clear=1, otherwise to UPD_READ with x/y/free latched.
REQ-019 CLR_INIT SHALL last 1 cycle with reset_counter=1, zero_cell=1 and write_enable=0, then go to CLR_RUN.
REQ-020 CLR_RUN SHALL assert zero_cell=1, write_enable=1 and enable_counter=1 each cycle.
REQ-021 When count_done=1 in CLR_RUN, that cycle's write SHALL still occur, and the next state SHALL be DONE.
REQ-022 UPD_READ SHALL hold x/y at the latched cell, write_enable=0 and zero_cell=0 for RAM_LATENCY cycles (internal down-counter), then go to UPD_WRITE.
REQ-023 UPD_WRITE SHALL last 1 cycle and drive cell_is_free=latched free.
REQ-024 In UPD_WRITE, write_enable SHALL be 1 unless (free and data_out==SAT_MIN) or (!free and data_out==SAT_MAX); a suppressed write SHALL set a saturated flag.
REQ-025 DONE SHALL last 1 cycle with done=1, saturated=flag, all datapath strobes 0, then return to IDLE.
REQ-026 In IDLE: x/y SHALL hold their last value, and zero_cell, write_enable, reset_counter and enable_counter SHALL be 0.
REQ-027 Latency SHALL be: update accept-to-done = RAM_LATENCY+2 cycles; clear accept-to-done = 2 + N cycles, where N is the number of CLR_RUN cycles.
REQ-028 A cmd_valid arriving while busy SHALL be held off (cmd_ready=0), not dropped; the requester holds cmd_valid high until accepted.

Reset
REQ-029 Asserting reset SHALL force IDLE immediately, including mid-clear or mid-update; the aborted command produces no done.
REQ-030 Reset values SHALL be: cmd_ready=1; done, saturated, zero_cell, write_enable, cell_is_free, reset_counter and enable_counter = 0; x=0; y=0; latched free=0; latency counter=0.
REQ-031 After reset releases, no datapath write SHALL occur until a command is accepted; an interrupted clear leaves the map partially cleared and the host reissues it.

Structure
REQ-032 A shared package occupancy_pkg SHALL hold the state enum type occ_state_t, the X_WIDTH=5 and Y_WIDTH=4 constants, and the default saturation limits.
REQ-033 One sub-module, occupancy_sat_check (combinational: data_out, free, limits -> suppress), SHALL be used; everything else is flat in occupancy_control.

Verification
REQ-034 Reset, then cmd_clear=1 with the datapath model raising count_done on the 512th CLR_RUN cycle -> reset_counter pulses 1 cycle, then 512 write_enable=1 cycles with zero_cell=1, then done at accept+514.
REQ-035 Update x=3, y=7, free=0, data_out=8'd10, RAM_LATENCY=1 -> write_enable in UPD_WRITE, cell_is_free=0, done at accept+3, saturated=0.
REQ-036 Update free=1 with data_out=8'd0 -> write_enable never asserted, done=1 and saturated=1 together.
REQ-037 Update free=0 with data_out=8'd255 -> write suppressed, saturated=1; then repeat with data_out=8'd254 -> write occurs, saturated=0.
REQ-038 Assert reset on the 100th CLR_RUN cycle -> all strobes 0 in the same cycle, no done, cmd_ready=1 after release; a new update then completes normally.
REQ-039 Hold cmd_valid high with two back-to-back updates -> second accepted only in the cycle after DONE; cmd_clear=1 with cmd_free=1 -> clear executed.
